// File: rtl/tone_generator.sv
// Purpose : square-wave tone synthesiser with PWM volume envelope and output gating.
// Latency : square_wave follows a sampled tone by 1 edge; speaker_out lags square_wave by 1 cycle.
// Backpressure: none. tone is sampled only on IDLE cycles or half-period boundaries.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   tone            requested half-period in cycles (0 = silence)
//   output_enable   1 passes audio to speaker_out, 0 forces it low
//   volume          PWM duty level, duty = (volume+1)/2^VOL_WIDTH
//   square_wave     raw registered square wave
//   tone_active     high while a non-zero period is active
//   speaker_out     gated, volume-modulated registered audio
module tone_generator #(
    parameter int PERIOD_WIDTH = 24,
    parameter int VOL_WIDTH    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PERIOD_WIDTH-1:0] tone,
    input  logic                    output_enable,
    input  logic [VOL_WIDTH-1:0]    volume,
    output logic                    square_wave,
    output logic                    tone_active,
    output logic                    speaker_out
);

    localparam logic [VOL_WIDTH-1:0] PWM_LAST = {VOL_WIDTH{1'b1}};

    logic [PERIOD_WIDTH-1:0] active_period;
    logic [PERIOD_WIDTH-1:0] half_cnt;
    logic                    sq;
    logic [VOL_WIDTH-1:0]    pwm_cnt;
    logic [VOL_WIDTH-1:0]    vol_q;
    logic                    pwm_on;
    logic                    at_boundary;

    // Last cycle of the current half-period. Only meaningful while running.
    assign at_boundary = (half_cnt == active_period - PERIOD_WIDTH'(1));
    assign pwm_on      = (pwm_cnt <= vol_q);
    assign tone_active = (active_period != '0);
    assign square_wave = sq;

    // Pitch engine: the period register is reloaded only while idle or on a
    // half-period boundary, so a mid-half tone change can never shorten or
    // stretch the half already in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_period <= '0;
            half_cnt      <= '0;
            sq            <= 1'b0;
        end else if (active_period == '0) begin
            active_period <= tone;
            half_cnt      <= '0;
            sq            <= (tone != '0);
        end else if (at_boundary) begin
            active_period <= tone;
            half_cnt      <= '0;
            // A zero tone at the boundary ends the note after a full half.
            sq            <= (tone != '0) ? ~sq : 1'b0;
        end else begin
            half_cnt      <= half_cnt + PERIOD_WIDTH'(1);
        end
    end

    // Volume envelope: free-running frame; the duty level is latched on the
    // last cycle of a frame so a frame is never split between two levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            vol_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + VOL_WIDTH'(1);
            if (pwm_cnt == PWM_LAST) begin
                vol_q <= volume;
            end
        end
    end

    // Output stage: enable gates only the pin, never the pitch phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speaker_out <= 1'b0;
        end else begin
            speaker_out <= output_enable & sq & pwm_on;
        end
    end

endmodule

// File: tb/tb_tone_generator.sv
// Purpose : self-checking bench for tone_generator (scoreboard queue + monitor).
// Latency : expectations are pushed just after each edge and popped on the following falling edge.
// Backpressure: not applicable; one expected sample per clock.
module tb_tone_generator;

    localparam int PW = 24;
    localparam int VW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] tone;
    logic          output_enable;
    logic [VW-1:0] volume;
    logic          square_wave;
    logic          tone_active;
    logic          speaker_out;

    tone_generator #(.PERIOD_WIDTH(PW), .VOL_WIDTH(VW)) dut (
        .clk           (clk),
        .rst           (rst),
        .tone          (tone),
        .output_enable (output_enable),
        .volume        (volume),
        .square_wave   (square_wave),
        .tone_active   (tone_active),
        .speaker_out   (speaker_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected {square_wave, tone_active, speaker_out} after each edge.
    logic [2:0] exp_q[$];

    // Bench-side tracking used to derive the expected speaker pin.
    logic          m_sq;
    logic [VW-1:0] m_volq;
    int            cyc;

    function automatic void chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares one queued expectation per falling edge.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("square_wave", square_wave, e[2]);
                chk("tone_active", tone_active, e[1]);
                chk("speaker_out", speaker_out, e[0]);
            end
        end
    end

    // One clock edge with the hand-derived square_wave / tone_active values
    // for the state just after the edge. The speaker pin is sq one cycle late,
    // gated by enable and by the duty window of the current frame.
    task automatic step(input logic exp_sq, input logic exp_act);
        logic          oe_s;
        logic [VW-1:0] vol_s;
        logic [VW-1:0] pb;
        logic          e_spk;
        oe_s  = output_enable;
        vol_s = volume;
        @(posedge clk);
        pb    = VW'(cyc % (1 << VW));
        e_spk = oe_s & m_sq & (pb <= m_volq);
        if (pb == VW'((1 << VW) - 1)) m_volq = vol_s;
        cyc++;
        m_sq = exp_sq;
        #1;
        exp_q.push_back({exp_sq, exp_act, e_spk});
    endtask

    task automatic half(input int len, input logic level);
        for (int i = 0; i < len; i++) step(level, 1'b1);
    endtask

    task automatic idle(input int len);
        for (int i = 0; i < len; i++) step(1'b0, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        rst    = 1'b0;
        m_sq   = 1'b0;
        m_volq = '0;
        cyc    = 0;
    endtask

    initial begin
        rst           = 1'b1;
        tone          = '0;
        output_enable = 1'b1;
        volume        = 3'd7;
        #1;
        chk("reset square_wave", square_wave, 1'b0);
        chk("reset tone_active", tone_active, 1'b0);
        chk("reset speaker_out", speaker_out, 1'b0);
        repeat (2) @(posedge clk);
        release_reset();

        // Silence while idle with tone 0.
        idle(3);

        // Basic pitch: 4 high / 4 low.
        tone = 24'd4;
        half(4, 1'b1); half(4, 1'b0); half(4, 1'b1); half(4, 1'b0);

        // Glitch-free change: switch to 6 two cycles into a high half.
        half(2, 1'b1);
        tone = 24'd6;
        half(2, 1'b1); half(6, 1'b0); half(6, 1'b1);

        // Stop: tone 5, then drop to 0 mid-half; the half still lasts 5.
        tone = 24'd5;
        half(5, 1'b0);
        half(2, 1'b1);
        tone = 24'd0;
        half(3, 1'b1);
        idle(4);

        // Volume: duty 4/8, then 1/8 from the next frame.
        volume = 3'd3;
        tone   = 24'd16;
        half(16, 1'b1); half(16, 1'b0);
        half(3, 1'b1);
        volume = 3'd0;
        half(13, 1'b1); half(16, 1'b0); half(16, 1'b1);

        // Enable gating: pitch keeps running with the pin forced low.
        volume        = 3'd7;
        tone          = 24'd3;
        output_enable = 1'b0;
        half(3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            half(3, 1'b1); half(3, 1'b0);
        end
        output_enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            half(3, 1'b1); half(3, 1'b0);
        end

        // Asynchronous reset in the middle of a high half.
        tone = 24'd4;
        half(4, 1'b1); half(4, 1'b0); half(2, 1'b1);
        @(negedge clk);
        #1;
        chk("pre-reset square_wave", square_wave, 1'b1);
        rst = 1'b1;
        #1;
        chk("async square_wave", square_wave, 1'b0);
        chk("async tone_active", tone_active, 1'b0);
        chk("async speaker_out", speaker_out, 1'b0);
        @(posedge clk);
        release_reset();
        half(4, 1'b1); half(4, 1'b0); half(4, 1'b1);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard drained", exp_q.size() == 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_generator.md
# tone_generator

Audio output stage directly downstream of the music streamer. Consumes the streamer's 24-bit `tone` word, a half-period in clock cycles, and produces a square wave at that pitch. The square wave is gated by a PWM volume envelope and an output enable to drive the board's 1-bit speaker/audio pin. Period changes take effect only on half-period boundaries, so a tone change never produces a runt pulse.

## Interface
- `PERIOD_WIDTH`, 24: width of `tone` and of the half-period counter.
- `VOL_WIDTH`, 3: width of `volume`; the PWM frame is 2^VOL_WIDTH cycles.

- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `tone`  input  PERIOD_WIDTH  requested half-period in cycles; 0 = silence.
- `output_enable`  input  1  1 passes audio to `speaker_out`; 0 forces it low.
- `volume`  input  VOL_WIDTH  duty level; duty = (volume+1)/2^VOL_WIDTH.
- `square_wave`  output  1  raw, ungated square wave (registered).
- `tone_active`  output  1  1 when the active period is non-zero.
- `speaker_out`  output  1  gated, volume-modulated audio (registered).

## Operation
- State:
  - `active_period` (PERIOD_WIDTH).
  - `half_cnt` (PERIOD_WIDTH).
  - `sq` (drives `square_wave`).
  - `pwm_cnt` (VOL_WIDTH).
  - `vol_q` (VOL_WIDTH).
  - `speaker_out` register.
- Reset values: every register listed above is 0, so `square_wave`=0, `tone_active`=0 and `speaker_out`=0.
- IDLE (`active_period`==0):
  - Each cycle, load `active_period`<=`tone`.
  - If `tone`!=0: `sq`<=1 and `half_cnt`<=0, starting the high half.
  - If `tone`==0: `sq` stays 0 and `half_cnt` stays 0.
- RUN (`active_period`!=0):
  - If `half_cnt` != `active_period`-1: `half_cnt` increments.
  - At `half_cnt` == `active_period`-1 (the boundary):
    - `half_cnt`<=0.
    - `active_period`<=`tone` (sampled that cycle).
    - If the sampled `tone`!=0: `sq`<=~`sq`.
    - If the sampled `tone`==0: `sq`<=0, and the block returns to IDLE.
- `tone` changes between boundaries are ignored. Only the value present on a boundary cycle, or on any IDLE cycle, is used.
- `active_period`=1 is legal: `sq` toggles every cycle, giving a period of 2 cycles.
- `tone_active` = (`active_period`!=0), combinational from the register.
- PWM:
  - `pwm_cnt` is free-running and wraps from 2^VOL_WIDTH-1 to 0.
  - `vol_q`<=`volume` only on the cycle where `pwm_cnt` == 2^VOL_WIDTH-1, so volume changes never split a frame.
  - `pwm_on` = (`pwm_cnt` <= `vol_q`).
- Output: `speaker_out`<=`output_enable` & `sq` & `pwm_on`. All operands are current-cycle register/input values.
- `output_enable` does not affect `sq`, `half_cnt` or `pwm_cnt`. Pitch phase is preserved across enable toggles.

## Timing
- Start from IDLE:
  - Edge N samples `tone`=T!=0.
  - After edge N: `sq`=1. `sq` stays high for exactly T cycles, then low for T cycles. Full period = 2T cycles.
- `speaker_out` lags `sq` by exactly 1 cycle. With `output_enable`=1 and `vol_q` at maximum, it is `sq` delayed by one cycle.
- Boundary loads:
  - A new `tone` sampled at a boundary sets the length of the very next half-period.
  - Latency from a `tone` change to its effect is 0 to old T-1 cycles plus 1 edge.
- Stop: a transition to `tone`=0 completes the current half-period, then `sq`=0 and `tone_active`=0 from the next cycle. No partial pulse is produced.
- Volume: a new `volume` takes effect at the start of the next PWM frame. That is at most 2^VOL_WIDTH cycles later, plus the 1-cycle output register.
- Asynchronous reset:
  - Asserting `rst` mid-operation clears all outputs immediately, with no clock needed.
  - After deassertion, the block is in IDLE and starts on the first edge that samples `tone`!=0.

## Test plan
- Basic pitch: reset, then `tone`=4, `volume`=7, `output_enable`=1 → `square_wave` repeats 4 high / 4 low. `speaker_out` is identical, delayed 1 cycle. `tone_active`=1.
- Glitch-free change: `tone`=4, switched to 6 two cycles into a high half → that high half still lasts 4 cycles. The following halves last 6 cycles each.
- Stop: `tone`=5 running, set to 0 mid-half → the half completes its 5 cycles. Then `square_wave`=0 and `tone_active`=0 persist, and `speaker_out` reaches 0 one cycle later.
- Volume: `tone`=16, `volume`=3, `output_enable`=1 → during each high half, `speaker_out` is high on 4 of every 8 cycles (`pwm_cnt` 0..3). Changing `volume` to 0 mid-frame → takes effect at the next frame with 1 of 8 cycles high.
- Enable gating: `tone`=3, `output_enable`=0 for 20 cycles → `speaker_out`=0 throughout while `square_wave` keeps toggling every 3 cycles. Re-enabling resumes output without any phase reset.
- Async reset: assert `rst` between edges while `tone`=4 is running → `square_wave`, `tone_active` and `speaker_out` go to 0 before the next edge. After release with `tone`=4, the first high half is 4 cycles.
